// File: rtl/bert_arbiter_pkg.sv
// Shared FSM state encoding and BRAM address composition for the tile fetch/writeback logic.
package bert_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITING = 2'd1,
        DONE    = 2'd2
    } wb_state_e;

    // Callers truncate the result to their own address width.
    function automatic logic [31:0] compose_addr(input logic [31:0] ptr,
                                                 input logic [31:0] n,
                                                 input logic [31:0] off);
        return ptr * n + off;
    endfunction

endpackage

// File: rtl/writeback_logic_gen_tile_serializer.sv
// Holds one captured result tile and walks an offset counter across its BRAM words.
module tile_serializer
    import bert_arbiter_pkg::*;
#(
    parameter int NUM_WRITES_PER_TILE = 2,
    parameter int DATA_WIDTH          = 256,
    parameter int OFF_W               = $clog2(NUM_WRITES_PER_TILE)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      load_i,
    input  logic                                      step_i,
    input  logic [NUM_WRITES_PER_TILE*DATA_WIDTH-1:0] tile_data_i,
    output logic [OFF_W-1:0]                          offset_o,
    output logic                                      last_o,
    output logic [DATA_WIDTH-1:0]                     word_o
);

    logic [NUM_WRITES_PER_TILE-1:0][DATA_WIDTH-1:0] tile_q;
    logic [OFF_W-1:0]                               offset_q, offset_d;

    assign last_o   = (offset_q == OFF_W'(NUM_WRITES_PER_TILE - 1));
    assign offset_o = offset_q;
    assign word_o   = tile_q[offset_q];

    always_comb begin
        offset_d = offset_q;
        if (load_i)
            offset_d = '0;
        else if (step_i)
            offset_d = last_o ? '0 : offset_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q   <= '0;
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
            if (load_i)
                tile_q <= tile_data_i;
        end
    end

endmodule

// File: rtl/writeback_logic_gen.sv
// Accepts one result tile, serializes it into consecutive BRAM words, then advances the tile pointer.
module writeback_logic_gen
    import bert_arbiter_pkg::*;
#(
    parameter int NUM_WRITES_PER_TILE = 2,
    parameter int DATA_WIDTH          = 256,
    parameter int ADDR_WIDTH          = 11,
    parameter int MAX_TILES           = 384,
    parameter int PTR_WIDTH           = 9
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      reset_addr_counter,
    input  logic                                      tile_valid,
    input  logic [NUM_WRITES_PER_TILE*DATA_WIDTH-1:0] tile_data,
    output logic                                      tile_ready,
    output logic [ADDR_WIDTH-1:0]                     bram_addr,
    output logic [DATA_WIDTH-1:0]                     bram_wdata,
    output logic                                      bram_en,
    output logic                                      bram_we,
    output logic                                      write_done,
    output logic [PTR_WIDTH-1:0]                      tile_ptr,
    output logic                                      buffer_full
);

    localparam int OFF_W = $clog2(NUM_WRITES_PER_TILE);

    wb_state_e            state_q;
    logic [PTR_WIDTH-1:0] ptr_q;
    logic                 full_q;
    logic                 clr_q;

    logic                  handshake;
    logic                  writing;
    logic                  last;
    logic [OFF_W-1:0]      offset;
    logic [DATA_WIDTH-1:0] word;

    assign handshake = (state_q == IDLE) && tile_valid && !full_q;
    assign writing   = (state_q == WRITING);

    tile_serializer #(
        .NUM_WRITES_PER_TILE (NUM_WRITES_PER_TILE),
        .DATA_WIDTH          (DATA_WIDTH),
        .OFF_W               (OFF_W)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (handshake),
        .step_i      (writing),
        .tile_data_i (tile_data),
        .offset_o    (offset),
        .last_o      (last),
        .word_o      (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reset_addr_counter) begin
                        ptr_q  <= '0;
                        full_q <= 1'b0;
                    end
                    if (handshake)
                        state_q <= WRITING;
                end
                WRITING: begin
                    // A clear arriving mid-tile is deferred so the tile lands at its original addresses.
                    if (reset_addr_counter)
                        clr_q <= 1'b1;
                    if (last)
                        state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    clr_q   <= 1'b0;
                    if (reset_addr_counter || clr_q) begin
                        ptr_q  <= '0;
                        full_q <= 1'b0;
                    end else if (ptr_q == PTR_WIDTH'(MAX_TILES - 1)) begin
                        ptr_q  <= '0;
                        full_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tile_ready  = rst_n && (state_q == IDLE) && !full_q;
    assign bram_en     = writing;
    assign bram_we     = writing;
    assign write_done  = (state_q == DONE);
    assign tile_ptr    = ptr_q;
    assign buffer_full = full_q;
    assign bram_addr   = writing ? ADDR_WIDTH'(compose_addr(32'(ptr_q), 32'(NUM_WRITES_PER_TILE), 32'(offset)))
                                 : '0;
    assign bram_wdata  = writing ? word : '0;

endmodule
